// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one start/done FP adder among N_REQ requesters; result one cycle after done.
// Accepts only in IDLE (req_ready combinational), so a new op waits for the previous response or abort.
module fp_add_arbiter #(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_sub,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_timeout,
  output logic                   busy,
  output logic                   fa_start,
  output logic [WIDTH-1:0]       fa_a,
  output logic [WIDTH-1:0]       fa_b,
  input  logic                   fa_done,
  input  logic [WIDTH-1:0]       fa_result
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_RESP   = 3'd2;
  localparam logic [2:0] S_ABORT1 = 3'd3;
  localparam logic [2:0] S_ABORT2 = 3'd4;

  logic [2:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    grant;
  logic [TW-1:0]    wd;
  logic [WIDTH-1:0] result;

  logic [IW-1:0]    pick;
  logic             pick_found;
  logic             xfer;
  int               idx;

  // Walk downwards so the nearest index after ptr is the last one written.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        pick       = idx[IW-1:0];
        pick_found = 1'b1;
      end
    end
  end

  assign xfer      = (state == S_IDLE) && pick_found;
  assign req_ready = xfer ? (N_REQ'(1) << pick) : '0;

  assign fa_start     = (state == S_WAIT);
  assign busy         = (state != S_IDLE);
  assign resp_valid   = ((state == S_RESP) || (state == S_ABORT2)) ? (N_REQ'(1) << grant) : '0;
  assign resp_data    = (state == S_RESP) ? result : '0;
  assign resp_timeout = (state == S_ABORT2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= IW'(N_REQ - 1);
      grant  <= '0;
      wd     <= '0;
      result <= '0;
      fa_a   <= '0;
      fa_b   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            fa_a  <= req_a[int'(pick)*WIDTH +: WIDTH];
            // Subtraction is folded into the operand by flipping B's sign bit.
            fa_b  <= req_b[int'(pick)*WIDTH +: WIDTH] ^ {req_sub[pick], {(WIDTH-1){1'b0}}};
            grant <= pick;
            ptr   <= pick;
            wd    <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wd <= wd + TW'(1);
          if (fa_done) begin
            result <= fa_result;
            state  <= S_RESP;
          end else if (wd == TW'(TIMEOUT - 1)) begin
            state <= S_ABORT1;
          end
        end
        S_RESP:   state <= S_IDLE;
        S_ABORT1: state <= S_ABORT2;
        S_ABORT2: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a latency-programmable adder model and a response scoreboard.
module tb_fp_add_arbiter;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           resp_timeout;
  logic           busy;
  logic           fa_start;
  logic [W-1:0]   fa_a;
  logic [W-1:0]   fa_b;
  logic           fa_done;
  logic [W-1:0]   fa_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int lat     = 5;
  bit done_en = 1'b1;
  bit spur    = 1'b0;
  int cnt     = 0;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    logic       to;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  fp_add_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .busy(busy), .fa_start(fa_start), .fa_a(fa_a), .fa_b(fa_b),
    .fa_done(fa_done), .fa_result(fa_result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fake_add(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4000_0000 && b == 32'hBF80_0000) return 32'h3F80_0000;
    return a + b;
  endfunction

  // Adder model: done rises in the lat-th consecutive cycle of start.
  always @(posedge clk) cnt <= fa_start ? cnt + 1 : 0;
  assign fa_done   = spur | (done_en & fa_start & (cnt == lat - 1));
  assign fa_result = fake_add(fa_a, fa_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if ((req_valid & req_ready) != '0) begin
        m_e.idx = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) m_e.idx = i;
        m_e.to   = !done_en;
        m_e.data = done_en ? fake_add(req_a[m_e.idx*W +: W],
                                      req_b[m_e.idx*W +: W] ^ {req_sub[m_e.idx], 31'b0}) : '0;
        sb.push_back(m_e);
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          m_e = sb.pop_front();
          chk("sb_resp_valid", 64'(resp_valid), 64'(1 << m_e.idx));
          chk("sb_resp_data", 64'(resp_data), 64'(m_e.data));
          chk("sb_resp_timeout", 64'(resp_timeout), 64'(m_e.to));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_resp(input string tag);
    for (int k = 0; k < 100 && resp_valid == '0; k++) tick();
    chk(tag, 64'(resp_valid != '0), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 100 && busy; k++) tick();
    chk(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    int t0;
    int ng;
    int g[4];
    int tx[4];
    bit all_hi;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_timeout", 64'(resp_timeout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fa_start", 64'(fa_start), 64'd0);
    chk("rst_fa_a", 64'(fa_a), 64'd0);
    chk("rst_fa_b", 64'(fa_b), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single add
    lat = 5;
    req_a[0 +: W] = 32'h3F80_0000; req_b[0 +: W] = 32'h4000_0000; req_sub[0] = 1'b0;
    req_valid = 2'b01;
    #1;
    t0 = cyc;
    chk("add_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    chk("add_fa_start", 64'(fa_start), 64'd1);
    chk("add_fa_a", 64'(fa_a), 64'h3F80_0000);
    chk("add_fa_b", 64'(fa_b), 64'h4000_0000);
    wait_resp("add_resp_seen");
    chk("add_latency", 64'(cyc - t0), 64'd6);
    chk("add_resp_start_low", 64'(fa_start), 64'd0);
    tick();
    wait_idle("add_idle");

    // Subtract from requester 1
    req_a[W +: W] = 32'h4000_0000; req_b[W +: W] = 32'h3F80_0000; req_sub[1] = 1'b1;
    req_valid = 2'b10;
    #1;
    chk("sub_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = '0;
    chk("sub_fa_b", 64'(fa_b), 64'hBF80_0000);
    chk("sub_fa_start", 64'(fa_start), 64'd1);
    wait_resp("sub_resp_seen");
    chk("sub_resp_valid", 64'(resp_valid), 64'b10);
    tick();
    wait_idle("sub_idle");

    // Contention
    lat = 2;
    req_a = {32'h0101_0101, 32'h1111_0000};
    req_b = {32'h1010_1010, 32'h0000_2222};
    req_sub = 2'b10;
    for (int i = 0; i < 4; i++) begin g[i] = -1; tx[i] = -1; end
    ng = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      #1;
      if ((req_ready & req_valid) != '0) begin
        g[ng]  = req_ready[1] ? 1 : 0;
        tx[ng] = cyc;
        ng++;
      end
      tick();
      if (ng == 4) req_valid = '0;
    end
    req_valid = '0;
    chk("cont_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) chk("cont_grant", 64'(g[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++) chk("cont_spacing", 64'(tx[i] - tx[i-1]), 64'd4);
    wait_idle("cont_idle");
    tick();

    // Timeout
    done_en = 1'b0;
    req_a[0 +: W] = 32'h1234_5678; req_b[0 +: W] = 32'h0000_0001; req_sub = '0;
    req_valid = 2'b01;
    #1;
    t0 = cyc;
    chk("to_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    all_hi = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      if (!fa_start) all_hi = 1'b0;
      tick();
    end
    chk("to_start_high", 64'(all_hi), 64'd1);
    chk("to_start_low", 64'(fa_start), 64'd0);
    chk("to_abort1_quiet", 64'(resp_valid), 64'd0);
    tick();
    chk("to_resp_valid", 64'(resp_valid), 64'b01);
    chk("to_resp_timeout", 64'(resp_timeout), 64'd1);
    chk("to_resp_data", 64'(resp_data), 64'd0);
    tick();
    done_en = 1'b1;
    lat = 3;
    req_valid = 2'b10;
    #1;
    chk("to_next_cycle", 64'(cyc - t0), 64'd19);
    chk("to_next_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = '0;
    wait_resp("to_next_resp");
    tick();
    wait_idle("to_idle");

    // Reset during WAIT
    lat = 10;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    chk("rw_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    tick();
    chk("rw_fa_start", 64'(fa_start), 64'd0);
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_resp_valid", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rw_first_grant", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    lat = 2;
    wait_resp("rw_resp");
    tick();
    wait_idle("rw_idle");

    // Spurious done while idle
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("spur_resp_valid", 64'(resp_valid), 64'd0);
      chk("spur_busy", 64'(busy), 64'd0);
    end
    spur = 1'b0;
    tick(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one floating-point adder datapath (start/done handshake, IEEE-754 single by default) among several requesters. It accepts one operation at a time and drives the adder's start level until done. It then returns the result to the granted requester, with a watchdog that aborts a hung operation. It sits between the FP issue ports of the core and the single float adder instance.

## Interface
- N_REQ, default 2: number of requesters (2..8).
- WIDTH, default 32: operand/result width; bit WIDTH-1 is the sign.
- TIMEOUT, default 64: maximum WAIT cycles before abort (>= 2).

- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  N_REQ  requester i has an operation pending.
- req_a  in  N_REQ*WIDTH  operand A of requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing.
- req_sub  in  N_REQ  1 = A-B, 0 = A+B.
- req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- resp_valid  out  N_REQ  one-hot, one-cycle result pulse to requester i.
- resp_data  out  WIDTH  result, valid with resp_valid.
- resp_timeout  out  1  high with resp_valid when the operation was aborted.
- busy  out  1  high whenever state != IDLE.
- fa_start  out  1  start level to adder.
- fa_a, fa_b  out  WIDTH  adder operands, registered, stable while fa_start high.
- fa_done  in  1  adder done level.
- fa_result  in  WIDTH  adder result, valid while fa_done high.

## Operation
- States: IDLE, WAIT, RESP, ABORT1, ABORT2.
- Reset values: state IDLE, all outputs 0, rr pointer = N_REQ-1, watchdog = 0, captured result = 0.
- IDLE: the grant is the first i with req_valid[i], searching ptr+1, ptr+2, … mod N_REQ. req_ready = onehot(grant), combinational in IDLE only.
  - On transfer: latch fa_a = req_a[i] and fa_b = req_b[i] ^ (req_sub[i] << (WIDTH-1)). Record grant index, set ptr = i, clear watchdog, go to WAIT.
  - With no req_valid: stay in IDLE, req_ready = 0.
- WAIT: fa_start = 1 and the watchdog increments each cycle.
  - fa_done = 1: capture fa_result, go to RESP. This takes priority over timeout in the same cycle.
  - Otherwise, watchdog == TIMEOUT-1: go to ABORT1.
- RESP: fa_start = 0; resp_valid[grant] = 1 and resp_data = captured result (registered output presented this cycle). Next state IDLE.
- ABORT1: fa_start = 0, no response; gives the adder a start-low cycle. Next state ABORT2.
- ABORT2: resp_valid[grant] = 1, resp_timeout = 1, resp_data = 0. Next state IDLE.
- fa_done outside WAIT is ignored.
- req_valid changes outside IDLE have no effect; a requester must hold its request until req_ready.
- The pointer advances only on transfer, so a requester that withdraws is skipped without penalty.
- Reset asserted in any state: the next edge returns every reset value, the in-flight operation is dropped, and no response is issued.

## Timing
- Transfer in cycle T (IDLE). fa_start is high from T+1.
- If fa_done is first sampled high in cycle D (D >= T+1), resp_valid is in D+1 and fa_start is low from D+1.
- Minimum transfer-to-transfer spacing is 3 cycles (IDLE, WAIT, RESP). fa_start is always low for at least one cycle between operations.
- Timeout: WAIT is entered at T+1 and lasts TIMEOUT cycles. ABORT1 is at T+1+TIMEOUT and the timeout response is at T+2+TIMEOUT.
- req_ready depends combinationally on state, ptr and req_valid; there is no path from fa_* to req_ready.

## Test plan
- Single add: req0 with a=0x3F800000, b=0x40000000, sub=0; the adder model raises done 5 cycles after start with 0x40400000. Required: req_ready[0] at T, fa_b=0x40000000, resp_valid[0] at T+6 with resp_data 0x40400000, resp_timeout=0.
- Subtract: req1 with a=0x40000000, b=0x3F800000, sub=1. Required: fa_b=0xBF800000 while fa_start high, resp_valid[1] with 0x3F800000.
- Contention: both req_valid held high from reset, adder done after 2 cycles. Required: grants alternate 0,1,0,1 and each transfer is 4 cycles after the previous one.
- Timeout: TIMEOUT=16, fa_done never asserted, transfer at T. Required: fa_start high T+1..T+16 and low at T+17. resp_valid[i] with resp_timeout=1 and resp_data=0 at T+18. A following request is accepted at T+19.
- Reset mid-WAIT: rst_n low for one cycle during WAIT. Required: next cycle fa_start=0, busy=0, no resp_valid. With both requesting afterwards, req0 is granted first.
- Spurious done: fa_done=1 while IDLE with no requests. Required: no resp_valid, state stays IDLE, busy=0.
